// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index, stage latency and the scoreboard
// issue-history record.
package cpu_types_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned LAT_W       = 8;
  localparam int unsigned DEF_NREG    = 32;
  localparam int unsigned DEF_ALU_LAT = 0;
  localparam int unsigned DEF_LD_LAT  = 1;

  typedef logic [REG_W-1:0] regbits_t;
  typedef logic [LAT_W-1:0] lat_t;

  typedef struct packed {
    logic     valid;
    regbits_t wreg;
    lat_t     lat;
  } hist_entry_t;

  // Remaining latency of a writer issued two cycles ago, clamped at zero.
  function automatic lat_t sat_sub2(lat_t x);
    return (x > lat_t'(2)) ? lat_t'(x - lat_t'(2)) : '0;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending-result down-counter for a single register.
module hazard_sb_entry #(
  parameter int unsigned CW = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          active,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  input  logic          force_en,
  input  logic [CW-1:0] force_val,
  output logic          busy
);

  logic [CW-1:0] cnt;

  // A fresh writer beats a redirect restore, which beats the normal countdown.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (active) begin
      if (load_en) begin
        cnt <= load_val;
      end else if (force_en) begin
        cnt <= force_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and pipeline hazard controller: tracks in-flight writers,
// stalls dependent instructions and rolls back on a control-flow redirect.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREG    = DEF_NREG,
  parameter int unsigned ALU_LAT = DEF_ALU_LAT,
  parameter int unsigned LD_LAT  = DEF_LD_LAT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            id_valid,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wr,
  input  logic [4:0]      id_wreg,
  input  logic            id_load,
  input  logic            redirect,
  input  logic            mem_wait,
  output logic            pc_en,
  output logic            id_en,
  output logic            ex_en,
  output logic            mem_en,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            flush_mem,
  output logic [NREG-1:0] busy,
  output logic [15:0]     stall_cycles
);

  localparam int unsigned MAX_LAT = (ALU_LAT > LD_LAT) ? ALU_LAT : LD_LAT;
  localparam int unsigned CW      = (MAX_LAT == 0) ? 1 : $clog2(MAX_LAT + 1);
  localparam int unsigned NPAD    = 1 << REG_W;

  logic            active;
  logic            hazard;
  logic            issue;
  lat_t            id_lat;
  logic [NREG-1:0] busy_raw;
  logic [NPAD-1:0] busy_pad;
  logic [CW-1:0]   restore_val;
  hist_entry_t     h0;
  hist_entry_t     h1;

  assign active   = !mem_wait;
  assign busy     = RST ? '0 : busy_raw;
  assign busy_pad = NPAD'(busy);
  assign hazard   = id_valid & ((id_use_rs & busy_pad[id_rs]) | (id_use_rt & busy_pad[id_rt]));
  assign issue    = active & id_valid & !hazard & !redirect;
  assign id_lat   = id_load ? LAT_W'(LD_LAT) : LAT_W'(ALU_LAT);

  // Squashing the EX writer hands the register back to the writer behind it.
  assign restore_val = (h1.valid && (h1.wreg == h0.wreg)) ? CW'(sat_sub2(h1.lat)) : '0;

  assign busy_raw[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(.CW(CW)) u_entry (
      .CLK       (CLK),
      .RST       (RST),
      .active    (active),
      .load_en   (issue & id_wr & (id_wreg == REG_W'(r)) & (id_lat != '0)),
      .load_val  (CW'(id_lat)),
      .force_en  (redirect & h0.valid & (h0.wreg == REG_W'(r))),
      .force_val (restore_val),
      .busy      (busy_raw[r])
    );
  end

  // Issue history and stall statistics advance only on active cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h0           <= '0;
      h1           <= '0;
      stall_cycles <= '0;
    end else if (active) begin
      h1 <= h0;
      h0 <= '{valid: issue & id_wr & (id_wreg != '0), wreg: id_wreg, lat: id_lat};
      if (!redirect && hazard && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    pc_en     = 1'b1;
    id_en     = 1'b1;
    ex_en     = 1'b1;
    mem_en    = 1'b1;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    if (!RST) begin
      if (mem_wait) begin
        pc_en  = 1'b0;
        id_en  = 1'b0;
        ex_en  = 1'b0;
        mem_en = 1'b0;
      end else if (redirect) begin
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (hazard) begin
        pc_en    = 1'b0;
        id_en    = 1'b0;
        flush_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default-latency and long-latency instances driven
// by shared stimulus and compared against a per-register latency model.
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       RST, id_valid, id_use_rs, id_use_rt, id_wr, id_load, redirect, mem_wait;
  logic [4:0] id_rs, id_rt, id_wreg;

  wire [6:0]  ctrl0, ctrl1;
  wire [31:0] busy0, busy1;
  wire [15:0] sc0, sc1;

  int checks   = 0;
  int failures = 0;

  int rem[2][32];
  bit hv[2][2];
  int hreg[2][2];
  int hlat[2][2];
  int stalls[2];

  always #5 CLK = ~CLK;

  hazard_scoreboard u_dut0 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wreg(id_wreg),
    .id_load(id_load), .redirect(redirect), .mem_wait(mem_wait),
    .pc_en(ctrl0[6]), .id_en(ctrl0[5]), .ex_en(ctrl0[4]), .mem_en(ctrl0[3]),
    .flush_id(ctrl0[2]), .flush_ex(ctrl0[1]), .flush_mem(ctrl0[0]),
    .busy(busy0), .stall_cycles(sc0)
  );

  hazard_scoreboard #(.NREG(32), .ALU_LAT(2), .LD_LAT(15)) u_dut1 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wreg(id_wreg),
    .id_load(id_load), .redirect(redirect), .mem_wait(mem_wait),
    .pc_en(ctrl1[6]), .id_en(ctrl1[5]), .ex_en(ctrl1[4]), .mem_en(ctrl1[3]),
    .flush_id(ctrl1[2]), .flush_ex(ctrl1[1]), .flush_mem(ctrl1[0]),
    .busy(busy1), .stall_cycles(sc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int alu_lat(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int ld_lat(int k);
    return (k == 0) ? 1 : 15;
  endfunction

  function automatic bit m_busy(int k, int r);
    return !RST && (r != 0) && (rem[k][r] > 0);
  endfunction

  function automatic bit m_hz(int k);
    return id_valid && ((id_use_rs && m_busy(k, int'(id_rs))) ||
                        (id_use_rt && m_busy(k, int'(id_rt))));
  endfunction

  function automatic logic [6:0] m_ctrl(int k);
    if (RST)      return 7'b1111000;
    if (mem_wait) return 7'b0000000;
    if (redirect) return 7'b1111111;
    if (m_hz(k))  return 7'b0011010;
    return 7'b1111000;
  endfunction

  function automatic logic [31:0] m_busyvec(int k);
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_busy(k, r);
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_update();
    bit hz, iss;
    int lat;
    int nrem[32];
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        for (int r = 0; r < 32; r++) rem[k][r] = 0;
        hv[k][0]  = 1'b0;
        hv[k][1]  = 1'b0;
        stalls[k] = 0;
      end else if (!mem_wait) begin
        hz  = m_hz(k);
        iss = id_valid && !hz && !redirect;
        lat = id_load ? ld_lat(k) : alu_lat(k);
        for (int r = 0; r < 32; r++) nrem[r] = (rem[k][r] > 0) ? rem[k][r] - 1 : 0;
        if (redirect && hv[k][0] && hreg[k][0] != 0)
          nrem[hreg[k][0]] = (hv[k][1] && hreg[k][1] == hreg[k][0]) ?
                             ((hlat[k][1] > 2) ? hlat[k][1] - 2 : 0) : 0;
        if (iss && id_wr && id_wreg != 5'd0 && lat != 0) nrem[int'(id_wreg)] = lat;
        for (int r = 0; r < 32; r++) rem[k][r] = nrem[r];
        hv[k][1]   = hv[k][0];
        hreg[k][1] = hreg[k][0];
        hlat[k][1] = hlat[k][0];
        hv[k][0]   = iss && id_wr && (id_wreg != 5'd0);
        hreg[k][0] = int'(id_wreg);
        hlat[k][0] = lat;
        if (!redirect && hz && stalls[k] < 65535) stalls[k]++;
      end
    end
  endtask

  task automatic sample();
    #1;
    check("ctrl0", 32'(ctrl0), 32'(m_ctrl(0)));
    check("busy0", busy0, m_busyvec(0));
    check("stall0", 32'(sc0), 32'(stalls[0]));
    check("ctrl1", 32'(ctrl1), 32'(m_ctrl(1)));
    check("busy1", busy1, m_busyvec(1));
    check("stall1", 32'(sc1), 32'(stalls[1]));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic instr(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int wreg, input bit ld);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wr     = wr;
    id_wreg   = 5'(wreg);
    id_load   = ld;
  endtask

  task automatic idle();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b0;
    mem_wait = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    sample();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int hz1, guard;
    RST = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) begin
      stalls[k] = 0;
      for (int r = 0; r < 32; r++) rem[k][r] = 0;
    end
    @(negedge CLK);
    do_reset();
    sample();
    check("rst_busy", busy0, 32'd0);
    check("rst_sc", 32'(sc0), 32'd0);

    // lw $2 ; add $3,$2,$4 -> one load-use stall
    instr(1, 0, 0, 0, 0, 1, 2, 1); sample(); check("lw_pc", 32'(ctrl0[6]), 32'd1); tick();
    instr(1, 2, 4, 1, 1, 1, 3, 0); sample(); check("lu_stall", 32'(ctrl0), 32'(7'b0011010)); tick();
    sample(); check("lu_go", 32'(ctrl0), 32'(7'b1111000)); tick();
    idle(); sample(); check("lu_sc", 32'(sc0), 32'd1); tick();

    // writes to $0 and ALU writes never stall the default instance
    instr(1, 0, 0, 0, 0, 1, 0, 0); tick();
    instr(1, 0, 0, 1, 1, 1, 6, 0); sample(); check("r0_pc", 32'(ctrl0[6]), 32'd1); tick();
    instr(1, 1, 1, 1, 1, 1, 5, 0); tick();
    instr(1, 5, 5, 1, 1, 1, 7, 0); sample(); check("alu_pc", 32'(ctrl0[6]), 32'd1); tick();
    idle(); sample(); check("alu_sc", 32'(sc0), 32'd1);

    // load-use stall held off by mem_wait
    do_reset();
    instr(1, 0, 0, 0, 0, 1, 2, 1); tick();
    instr(1, 2, 0, 1, 0, 1, 3, 0);
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("mw_ctrl", 32'(ctrl0), 32'd0);
      check("mw_busy2", 32'(busy0[2]), 32'd1);
      tick();
    end
    mem_wait = 1'b0;
    sample(); check("mw_stall", 32'(ctrl0), 32'(7'b0011010)); tick();
    sample(); check("mw_go", 32'(ctrl0), 32'(7'b1111000)); check("mw_sc", 32'(sc0), 32'd1); tick();

    // redirect squashes lw $5 in EX
    do_reset();
    instr(1, 0, 0, 0, 0, 1, 5, 1); tick();
    instr(1, 5, 0, 1, 0, 1, 6, 0);
    redirect = 1'b1;
    sample();
    check("rd_flush", 32'(ctrl0), 32'(7'b1111111));
    check("rd_busy5", 32'(busy0[5]), 32'd1);
    tick();
    redirect = 1'b0;
    sample();
    check("rd_clr5", 32'(busy0[5]), 32'd0);
    check("rd_pc", 32'(ctrl0[6]), 32'd1);
    tick();

    // reset asserted while a dependent instruction waits
    do_reset();
    instr(1, 0, 0, 0, 0, 1, 2, 1); tick();
    instr(1, 2, 0, 1, 0, 1, 3, 0);
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rs_busy", busy0, 32'd0);
      check("rs_ctrl", 32'(ctrl0), 32'(7'b1111000));
      tick();
    end
    RST = 1'b0;
    sample();
    check("rs_sc", 32'(sc0), 32'd0);
    check("rs_pc", 32'(ctrl0[6]), 32'd1);
    tick();

    // randomized traffic over a small register window
    for (int i = 0; i < 2000; i++) begin
      RST       = ($urandom_range(0, 59) == 0);
      mem_wait  = ($urandom_range(0, 5) == 0);
      redirect  = ($urandom_range(0, 9) == 0);
      instr($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      sample();
      tick();
    end

    // self-dependent load loop drives the long-latency instance into saturation
    do_reset();
    instr(1, 2, 0, 1, 0, 1, 2, 1);
    hz1   = 0;
    guard = 0;
    while (hz1 < 70000 && guard < 90000) begin
      if (m_hz(1)) hz1++;
      tick();
      guard++;
    end
    if (hz1 < 70000) check("sat_budget", 32'(hz1), 32'd70000);
    idle();
    sample();
    check("sat_sc1", 32'(sc1), 32'h0000FFFF);
    tick();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning architectural register count.
REQ-002 SHALL have parameter ALU_LAT, default 0, meaning dependent-stall cycles after an ALU writer.
REQ-003 SHALL have parameter LD_LAT, default 1, meaning dependent-stall cycles after a load writer.
REQ-004 SHALL have ports, one per line:
- CLK, in, 1: the one clock.
- RST, in, 1: reset, synchronous, active-high.
- id_valid, in, 1: ID holds a real instruction.
- id_rs, in, 5: ID source register.
- id_rt, in, 5: ID source register.
- id_use_rs, in, 1: ID reads rs.
- id_use_rt, in, 1: ID reads rt.
- id_wr, in, 1: ID writes a register.
- id_wreg, in, 5: ID destination register.
- id_load, in, 1: ID is LW.
- redirect, in, 1: jump/JR/JAL resolved in MEM.
- mem_wait, in, 1: data memory not ready.
- pc_en, out, 1: PC enable.
- id_en, out, 1: IF/ID latch enable.
- ex_en, out, 1: ID/EX latch enable.
- mem_en, out, 1: EX/MEM latch enable.
- flush_id, out, 1: flush IF/ID.
- flush_ex, out, 1: flush ID/EX.
- flush_mem, out, 1: flush EX/MEM.
- busy, out, NREG: per-register pending bit.
- stall_cycles, out, 16: hazard-stall performance count.

Function
REQ-005 SHALL hold one down-counter cnt[r], CW = clog2(max(ALU_LAT,LD_LAT)+1) bits, per register 1..NREG-1; busy[r] = (cnt[r]!=0); busy[0] always 0.
REQ-006 SHALL define active cycle = !mem_wait; a non-active cycle SHALL freeze counters, history and stall_cycles.
REQ-007 SHALL define hazard = id_valid & ((id_use_rs & busy[id_rs]) | (id_use_rt & busy[id_rt])); register 0 SHALL never cause hazard.
REQ-008 SHALL define issue = active & id_valid & !hazard & !redirect.
REQ-009 On issue with id_wr, id_wreg!=0 and lat!=0 (lat = id_load ? LD_LAT : ALU_LAT), cnt[id_wreg] SHALL load lat at the edge; the load SHALL take priority over the decrement of the same entry.
REQ-010 Every other nonzero counter SHALL decrement by 1 per active cycle, stall cycles included.
REQ-011 SHALL keep a 2-entry issue history {valid, reg, lat} shifting each active cycle: h0 = instruction now in EX, or a bubble when not issued; h1 = old h0.
REQ-012 Priority SHALL be RST > mem_wait > redirect > hazard > normal.
REQ-013 mem_wait: pc_en=id_en=ex_en=mem_en=0, all flushes 0.
REQ-014 redirect (active): flush_id=flush_ex=flush_mem=1 for that cycle, all enables 1, hazard ignored.
REQ-015 On redirect, if h0.valid, cnt[h0.reg] SHALL be set to (h1.valid & h1.reg==h0.reg) ? sat0(h1.lat-2) : 0; this SHALL override the REQ-010 decrement of that entry.
REQ-016 hazard (active, no redirect): pc_en=0, id_en=0, flush_ex=1, ex_en=mem_en=1; stall_cycles SHALL increment and saturate at 16'hFFFF.
REQ-017 Normal: all enables 1, all flushes 0.
REQ-018 Outputs SHALL be combinational from state and inputs; state SHALL update only on CLK rising edge.

Reset
REQ-019 RST SHALL clear all cnt, history valids and stall_cycles; reset SHALL win over issue, redirect and mem_wait in the same cycle.
REQ-020 While RST=1, outputs SHALL be pc_en=id_en=ex_en=mem_en=1, flushes 0, busy=0.

Structure
REQ-021 The history entry struct SHALL reside in cpu_types_pkg using regbits_t; the stage-latency defaults SHALL be package localparams.
REQ-022 Per-register counter SHALL be sub-module hazard_sb_entry, generated NREG-1 times.

Verification
REQ-023 RST=1 for 2 cycles mid-stall -> busy=0, stall_cycles=0, pc_en=1 next cycle.
REQ-024 Sequence lw $2 then add $3,$2,$4 (LD_LAT=1) -> exactly 1 cycle of pc_en=0, id_en=0, flush_ex=1; stall_cycles=1.
REQ-025 Sequence add $0 then read of $0, and add $5 then read of $5 with ALU_LAT=0 -> no stall.
REQ-026 Load-use stall with mem_wait=1 for 3 cycles -> enables 0, cnt[2] holds 1, then one stall cycle after mem_wait falls.
REQ-027 lw $5 in EX with redirect=1 -> flush_id=flush_ex=flush_mem=1, cnt[5]=0; next reader of $5 does not stall.
REQ-028 Drive 70000 hazard cycles -> stall_cycles=16'hFFFF.
